// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
//
// Arbitrates the single port of the 32x32 instruction memory between CPU
// instruction fetch and two maintenance services: a valid/ready loader burst
// and a full clear. Only one service runs at a time. Fetch is the default and
// is a combinational read-through. While a burst or clear is in progress the
// CPU is stalled and sees NOPs (all-zero words).
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   cpu_addr            CPU fetch word address
//   cpu_instr           fetched instruction, 0 while stalled
//   cpu_stall           high whenever the controller is not idle
//   ld_start            request a loader burst (sampled only when idle)
//   ld_base, ld_len     burst start address and length (1..DEPTH words)
//   ld_valid, ld_data   loader stream word and its valid
//   ld_ready            controller accepts a loader word this cycle
//   clr_start           request a full clear (sampled only when idle)
//   done                one-cycle pulse after a burst or clear completes
//   err                 one-cycle pulse after an illegal burst length
//   mem_a, mem_d        memory address and write data
//   mem_we_n            memory write enable, active low
//   mem_spo             memory combinational read data
// ---------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_stall,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              clr_start,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we_n,
  input  logic [DATA_W-1:0] mem_spo
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              len_ok;
  logic              last_word;

  assign len_ok    = (ld_len != '0) && (ld_len <= LEN_MAX);
  assign last_word = (remaining == LEN_ONE);

  // Sequencer: picks a service from idle, walks the write pointer through
  // the memory (wrapping naturally at the address width), and drops into a
  // single DONE cycle after the final write. err is registered so the reject
  // of a bad burst length is seen the cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          // clear wins a tie with a burst request; that burst request is
          // silently dropped rather than flagged
          if (clr_start) begin
            wr_ptr    <= '0;
            remaining <= LEN_MAX;
            state     <= S_CLEAR;
          end else if (ld_start) begin
            if (len_ok) begin
              wr_ptr    <= ld_base;
              remaining <= ld_len;
              state     <= S_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // the loader may stall indefinitely; only handshakes advance
          if (ld_valid) begin
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            remaining <= remaining - LEN_ONE;
            if (last_word) begin
              state <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          wr_ptr    <= wr_ptr + ADDR_W'(1);
          remaining <= remaining - LEN_ONE;
          if (last_word) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory port steering and CPU-facing outputs, decoded from the state.
  // The loader write strobe follows ld_valid in the same cycle so a word is
  // committed on the edge that completes its handshake.
  always_comb begin
    cpu_stall = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_a     = wr_ptr;
    mem_d     = '0;
    mem_we_n  = 1'b1;
    cpu_instr = '0;
    ld_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        mem_a     = cpu_addr;
        cpu_instr = mem_spo;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_d    = ld_data;
          mem_we_n = 1'b0;
        end
      end
      S_CLEAR: begin
        mem_we_n = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_load_ctrl
//
// Self-checking bench for imem_load_ctrl. A behavioural 32x32 memory with a
// combinational read port sits on the controller's memory pins and logs
// every committed write. Expected memory contents and write sequences are
// computed from the service rules (base + i mod 32, all-zero clear, etc.)
// and compared against the write log, the memory pins and CPU fetches.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 4 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_instr;
  logic              cpu_stall;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              clr_start;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we_n;
  logic [DATA_W-1:0] mem_spo;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t wr_log[$];

  int checks   = 0;
  int failures = 0;

  imem_load_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_addr (cpu_addr),
    .cpu_instr(cpu_instr),
    .cpu_stall(cpu_stall),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .clr_start(clr_start),
    .done     (done),
    .err      (err),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we_n (mem_we_n),
    .mem_spo  (mem_spo)
  );

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural memory: combinational read, write on rising edge while low
  assign mem_spo = mem[mem_a];

  always @(posedge clk) begin
    if (mem_we_n == 1'b0) begin
      mem[mem_a] = mem_d;
      wr_log.push_back({mem_a, mem_d});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ld_start  = 1'b0;
    clr_start = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    drive_idle();
    ld_base   = '0;
    ld_len    = '0;
    ld_data   = '0;
    cpu_addr  = 5'd5;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    #2;
    checks++;
    if ({cpu_stall, done, err, ld_ready, mem_we_n} !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got stall/done/err/ready/we_n=%b, expected 00001",
               {cpu_stall, done, err, ld_ready, mem_we_n});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    checks++;
    if (cpu_instr !== ref_mem[5]) begin
      failures++;
      $display("[TB] FAIL reset_fetch: got %h, expected %h", cpu_instr, ref_mem[5]);
    end
    checks++;
    if ({cpu_stall, ld_ready, mem_we_n, mem_a} !== {3'b001, 5'd5}) begin
      failures++;
      $display("[TB] FAIL reset_idle_port: got stall/ready/we_n/a=%b, expected 00100101",
               {cpu_stall, ld_ready, mem_we_n, mem_a});
    end
  endtask

  // one IDLE cycle with a random fetch; no pulses may be present
  task automatic idle_cycle();
    step();
    drive_idle();
    cpu_addr = 5'($urandom_range(0, 31));
    #3;
    checks++;
    if ({cpu_stall, done, err, mem_we_n} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL idle_flags: got stall/done/err/we_n=%b, expected 0001",
               {cpu_stall, done, err, mem_we_n});
    end
    checks++;
    if (cpu_instr !== ref_mem[cpu_addr]) begin
      failures++;
      $display("[TB] FAIL idle_fetch: addr %0d got %h, expected %h",
               cpu_addr, cpu_instr, ref_mem[cpu_addr]);
    end
  endtask

  task automatic fetch_sweep();
    for (int a = 0; a < DEPTH; a++) begin
      step();
      drive_idle();
      cpu_addr = 5'(a);
      #3;
      checks++;
      if (cpu_instr !== ref_mem[a]) begin
        failures++;
        $display("[TB] FAIL fetch_sweep: addr %0d got %h, expected %h", a, cpu_instr, ref_mem[a]);
      end
    end
  endtask

  // mode 0: ld_valid always high, 1: toggles 1,0,1,0..., 2: random with
  // random start noise. Ends in the DONE cycle so a following call issues
  // its start in the very first IDLE cycle.
  task automatic run_load(input logic [ADDR_W-1:0] base, input int len,
                          input int mode, input bit fixed_data);
    int                hs    = 0;
    int                cyc   = 0;
    int                bound = 8 * len + 20;
    logic              v;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_d[$];
    wr_log.delete();
    step();
    ld_start  = 1'b1;
    clr_start = 1'b0;
    ld_valid  = 1'b0;
    ld_base   = base;
    ld_len    = 6'(len);
    cpu_addr  = 5'($urandom_range(0, 31));
    #3;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_instr !== ref_mem[cpu_addr]) begin
      failures++;
      $display("[TB] FAIL load_start_fetch: got stall=%b instr=%h, expected stall=0 instr=%h",
               cpu_stall, cpu_instr, ref_mem[cpu_addr]);
    end
    step();
    ld_start = 1'b0;
    while (hs < len && cyc < bound) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      data     = fixed_data ? (32'hA000_0001 + 32'(hs)) : $urandom;
      ld_valid = v;
      ld_data  = data;
      if (mode == 2) begin
        ld_start  = 1'($urandom_range(0, 1));
        clr_start = 1'($urandom_range(0, 1));
        ld_len    = 6'($urandom_range(0, 63));
      end
      #3;
      checks++;
      if ({ld_ready, cpu_stall, done} !== 3'b110 || cpu_instr !== '0) begin
        failures++;
        $display("[TB] FAIL load_status: got ready/stall/done=%b instr=%h, expected 110 instr=0",
                 {ld_ready, cpu_stall, done}, cpu_instr);
      end
      checks++;
      if (mem_a !== 5'((int'(base) + hs) % DEPTH)) begin
        failures++;
        $display("[TB] FAIL load_addr: got %0d, expected %0d", mem_a, (int'(base) + hs) % DEPTH);
      end
      checks++;
      if (v) begin
        if (mem_we_n !== 1'b0 || mem_d !== data) begin
          failures++;
          $display("[TB] FAIL load_write: got we_n=%b d=%h, expected we_n=0 d=%h",
                   mem_we_n, mem_d, data);
        end
        exp_d.push_back(data);
        hs++;
      end else if (mem_we_n !== 1'b1) begin
        failures++;
        $display("[TB] FAIL load_backpressure_we: got we_n=%b, expected 1", mem_we_n);
      end
      cyc++;
      step();
    end
    drive_idle();
    if (hs < len) begin
      checks++;
      failures++;
      $display("[TB] FAIL load_timeout: got %0d handshakes, expected %0d", hs, len);
    end
    #3;
    checks++;
    if ({done, cpu_stall, mem_we_n, ld_ready} !== 4'b1110 || cpu_instr !== '0) begin
      failures++;
      $display("[TB] FAIL load_done: got done/stall/we_n/ready=%b instr=%h, expected 1110 instr=0",
               {done, cpu_stall, mem_we_n, ld_ready}, cpu_instr);
    end
    checks++;
    if (wr_log.size() != len) begin
      failures++;
      $display("[TB] FAIL load_write_count: got %0d, expected %0d", wr_log.size(), len);
    end
    for (int k = 0; k < hs; k++) begin
      ref_mem[(int'(base) + k) % DEPTH] = exp_d[k];
      if (k < wr_log.size()) begin
        checks++;
        if (wr_log[k] !== {5'((int'(base) + k) % DEPTH), exp_d[k]}) begin
          failures++;
          $display("[TB] FAIL load_write_order: entry %0d got %h, expected %h", k, wr_log[k],
                   {5'((int'(base) + k) % DEPTH), exp_d[k]});
        end
      end
    end
  endtask

  // full clear, optionally with a coincident burst request; includes the
  // first IDLE cycle afterwards
  task automatic run_clear(input bit with_ld);
    int stall_cycles = 0;
    wr_log.delete();
    step();
    clr_start = 1'b1;
    ld_start  = with_ld;
    ld_len    = 6'($urandom_range(1, 32));
    ld_base   = 5'($urandom_range(0, 31));
    ld_valid  = 1'b0;
    cpu_addr  = 5'($urandom_range(0, 31));
    #3;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_instr !== ref_mem[cpu_addr]) begin
      failures++;
      $display("[TB] FAIL clear_start_fetch: got stall=%b instr=%h, expected stall=0 instr=%h",
               cpu_stall, cpu_instr, ref_mem[cpu_addr]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step();
      clr_start = 1'($urandom_range(0, 1));
      ld_start  = 1'($urandom_range(0, 1));
      ld_len    = 6'($urandom_range(1, 32));
      ld_valid  = 1'($urandom_range(0, 1));
      ld_data   = $urandom;
      #3;
      if (cpu_stall === 1'b1) stall_cycles++;
      checks++;
      if (mem_we_n !== 1'b0 || mem_a !== 5'(i) || mem_d !== '0) begin
        failures++;
        $display("[TB] FAIL clear_write: cycle %0d got we_n=%b a=%0d d=%h, expected we_n=0 a=%0d d=0",
                 i, mem_we_n, mem_a, mem_d, i);
      end
      checks++;
      if ({ld_ready, done, err} !== 3'b000 || cpu_instr !== '0) begin
        failures++;
        $display("[TB] FAIL clear_outputs: cycle %0d got ready/done/err=%b instr=%h, expected 000 instr=0",
                 i, {ld_ready, done, err}, cpu_instr);
      end
    end
    step();
    drive_idle();
    #3;
    if (cpu_stall === 1'b1) stall_cycles++;
    checks++;
    if ({done, mem_we_n} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL clear_done: got done/we_n=%b, expected 11", {done, mem_we_n});
    end
    step();
    drive_idle();
    #3;
    checks++;
    if ({cpu_stall, done, err} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL clear_release: got stall/done/err=%b, expected 000",
               {cpu_stall, done, err});
    end
    checks++;
    if (stall_cycles != 33) begin
      failures++;
      $display("[TB] FAIL clear_stall_cycles: got %0d, expected 33", stall_cycles);
    end
    checks++;
    if (wr_log.size() != DEPTH) begin
      failures++;
      $display("[TB] FAIL clear_write_count: got %0d, expected %0d", wr_log.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic test_burst();
    run_load(5'd2, 3, 0, 1'b1);
    idle_cycle();
    step();
    cpu_addr = 5'd3;
    #3;
    checks++;
    if (cpu_instr !== 32'hA000_0002) begin
      failures++;
      $display("[TB] FAIL burst_fetch3: got %h, expected a0000002", cpu_instr);
    end
  endtask

  task automatic test_wrap();
    run_load(5'd30, 4, 1, 1'b0);
    idle_cycle();
  endtask

  task automatic test_clear();
    run_clear(1'b0);
    fetch_sweep();
  endtask

  task automatic test_illegal(input int len);
    wr_log.delete();
    step();
    ld_start  = 1'b1;
    clr_start = 1'b0;
    ld_valid  = 1'b0;
    ld_len    = 6'(len);
    ld_base   = 5'($urandom_range(0, 31));
    #3;
    checks++;
    if ({err, cpu_stall} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL illegal_start: len %0d got err/stall=%b, expected 00", len, {err, cpu_stall});
    end
    step();
    ld_start = 1'b0;
    #3;
    checks++;
    if ({err, cpu_stall, mem_we_n} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL illegal_err: len %0d got err/stall/we_n=%b, expected 101",
               len, {err, cpu_stall, mem_we_n});
    end
    step();
    #3;
    checks++;
    if ({err, cpu_stall} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL illegal_err_width: len %0d got err/stall=%b, expected 00", len, {err, cpu_stall});
    end
    checks++;
    if (wr_log.size() != 0) begin
      failures++;
      $display("[TB] FAIL illegal_no_write: got %0d writes, expected 0", wr_log.size());
    end
  endtask

  task automatic test_contention();
    run_clear(1'b1);
    fetch_sweep();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      run_load(5'($urandom_range(0, 31)), $urandom_range(1, 32), 2, 1'b0);
    end
    idle_cycle();
    fetch_sweep();
  endtask

  task automatic test_reset_mid_burst();
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    d0 = $urandom;
    d1 = $urandom;
    wr_log.delete();
    step();
    ld_start = 1'b1;
    ld_base  = 5'd8;
    ld_len   = 6'd5;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = d0;
    step();
    ld_data  = d1;
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    #1;
    checks++;
    if ({cpu_stall, done, mem_we_n, ld_ready} !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got stall/done/we_n/ready=%b, expected 0010",
               {cpu_stall, done, mem_we_n, ld_ready});
    end
    ref_mem[8] = d0;
    ref_mem[9] = d1;
    checks++;
    if (wr_log.size() != 2) begin
      failures++;
      $display("[TB] FAIL midreset_write_count: got %0d, expected 2", wr_log.size());
    end
    step();
    #3;
    rst_n = 1'b1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_no_done: got %b, expected 0", done);
    end
    idle_cycle();
    idle_cycle();
    fetch_sweep();
  endtask

  // watchdog: any hang ends the run with a failure line
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_burst();
    test_wrap();
    test_clear();
    test_illegal(0);
    test_illegal(33);
    test_illegal($urandom_range(34, 63));
    test_contention();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Owns the single port of the 32x32 instruction memory and shares it between CPU instruction fetch and a program loader.
- Three services, one at a time:
  - CPU fetch: default, combinational read-through.
  - Loader burst: valid/ready stream of words written from a base address.
  - Full clear: zeroes all 32 words.
- The CPU is stalled, and sees NOPs, whenever the controller is not in fetch mode.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 32, instruction word width.
- DEPTH, 32, number of words (2**ADDR_W).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_W  CPU fetch word address.
- cpu_instr  out  DATA_W  fetched instruction; 0 while stalled.
- cpu_stall  out  1  high when the CPU must hold its PC.
- ld_start  in  1  request a loader burst; sampled only in IDLE.
- ld_base  in  ADDR_W  first write address; latched with ld_start.
- ld_len  in  ADDR_W+1  burst length in words, legal 1..32; latched with ld_start.
- ld_valid  in  1  loader data valid.
- ld_data  in  DATA_W  loader word.
- ld_ready  out  1  controller accepts a word this cycle.
- clr_start  in  1  request a full clear; sampled only in IDLE.
- done  out  1  one-cycle pulse when a burst or clear completes.
- err  out  1  one-cycle pulse when ld_start is rejected.
- mem_a  out  ADDR_W  memory address.
- mem_d  out  DATA_W  memory write data.
- mem_we_n  out  1  memory write enable, active-low; memory writes on rising clk while low.
- mem_spo  in  DATA_W  memory combinational read data.

Behaviour:

Reset (async, rst_n=0):
- state=IDLE; wr_ptr=0; remaining=0; done=0; err=0.
- Outputs are those of IDLE.
- Reset mid-burst or mid-clear aborts. Words already written stay written. No done pulse.

FSM states: IDLE, LOAD, CLEAR, DONE. The state register is the only source of cpu_stall: cpu_stall = (state != IDLE).

IDLE:
- mem_a=cpu_addr, mem_we_n=1, mem_d=0, cpu_instr=mem_spo, ld_ready=0.
- clr_start=1: wr_ptr<=0, remaining<=DEPTH, go to CLEAR. clr_start has priority if it coincides with ld_start; that ld_start is dropped with no err.
- Else ld_start=1 with ld_len in 1..32: wr_ptr<=ld_base, remaining<=ld_len, go to LOAD.
- Else ld_start=1 with ld_len=0 or >32: err=1 for one cycle (registered, visible the next cycle), stay in IDLE.
- The CPU fetch in the start cycle is still served; stall is asserted from the next cycle.

LOAD:
- ld_ready=1, cpu_instr=0.
- ld_valid=1 (handshake): mem_a=wr_ptr, mem_d=ld_data, mem_we_n=0 in that same cycle (combinational). Then wr_ptr<=wr_ptr+1 mod 32, remaining<=remaining-1.
- If remaining==1 at the handshake, go to DONE.
- ld_valid=0: mem_we_n=1, mem_a=wr_ptr, nothing changes; the loader may idle indefinitely.
- Address wrap: base 30, len 4 writes 30, 31, 0, 1.
- ld_start and clr_start are ignored.

CLEAR:
- Every cycle: mem_a=wr_ptr, mem_d=0, mem_we_n=0, then wr_ptr increments and remaining decrements.
- Exactly 32 write cycles; after the write with remaining==1, go to DONE.
- ld_ready=0; ld_start and clr_start are ignored.

DONE:
- One cycle. mem_we_n=1, cpu_stall=1, cpu_instr=0.
- done=1 (decoded from state), then go to IDLE.

Completion latency: done appears the cycle after the last write. A new start is accepted from the first IDLE cycle after DONE.

Test Plan:
- Reset then fetch: rst_n low 3 cycles, memory preloaded, cpu_addr=5 -> cpu_instr=mem[5] same cycle, cpu_stall=0, mem_we_n=1, ld_ready=0.
- Burst load: ld_start, ld_base=2, ld_len=3, ld_valid held with data A0000001/A0000002/A0000003 -> mem[2..4] written in 3 consecutive cycles, done pulses 1 cycle later, cpu_stall falls the cycle after done, fetch of address 3 returns A0000002.
- Back-pressure and wrap: base=30, len=4, ld_valid toggling 1,0,1,0,... -> writes only on valid cycles to 30,31,0,1 in order; mem_we_n stays high on idle cycles; exactly 4 writes.
- Clear: clr_start -> 32 consecutive cycles with mem_we_n=0, addresses 0..31, all words read 0 afterwards; done at cycle 33; total stall 33 cycles.
- Illegal and contention cases: ld_start with ld_len=0 -> err pulse, no stall, no write. ld_start with ld_len=33 -> err pulse. ld_start and clr_start together -> CLEAR runs, no err. ld_start during CLEAR -> ignored.
- Reset mid-burst: base=8, len=5, assert rst_n low after 2 handshakes -> mem[8], mem[9] updated, mem[10..12] unchanged, state IDLE, no done, cpu_stall=0 immediately.
